// File: rtl/scan_pkg.sv
// Shared definitions for the mux scan/capture sequencer.
// Provides the sequencer state type and the fixed geometry of the scanned mux:
//   NUM_SRC - number of mux sources scanned
//   WIDTH   - width of each mux data word
//   SEL_W   - width of the mux select
//   CNT_W   - width of the settle-time counter (settle range 0..7)
//   SNAP_W  - width of the packed snapshot
package scan_pkg;

    localparam int unsigned NUM_SRC = 6;
    localparam int unsigned WIDTH   = 4;
    localparam int unsigned SEL_W   = 3;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned SNAP_W  = NUM_SRC * WIDTH;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StHold
    } scan_state_t;

endpackage

// File: rtl/slot_bank.sv
// Bank of NUM_SRC capture registers, one per mux source.
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset (clears all slots)
//   we         - write enable for the slot selected by idx
//   idx        - slot index; values >= NUM_SRC write nothing
//   d          - data written into slot[idx]
//   q          - packed contents, slot i in bits [i*WIDTH +: WIDTH]
module slot_bank
    import scan_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [SEL_W-1:0]  idx,
    input  logic [WIDTH-1:0]  d,
    output logic [SNAP_W-1:0] q
);

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_slot
        logic [WIDTH-1:0] slot_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                slot_q <= '0;
            end else if (we && (idx == SEL_W'(i))) begin
                slot_q <= d;
            end
        end

        assign q[i*WIDTH +: WIDTH] = slot_q;
    end

endmodule

// File: rtl/mux_scan_capture.sv
// Scan sequencer for the ALU result mux: steps the select through every source,
// waits SETTLE cycles on each, captures the mux output into a slot register and
// offers the packed snapshot over a valid/ready handshake.
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset
//   start_i    - scan request (dropped requests set ovr_o)
//   sel_o      - select driven to the mux, always 0..NUM_SRC-1
//   din_i      - mux output, combinational from sel_o
//   snap_o     - packed snapshot, slot i at bits [4i+3:4i]
//   valid_o    - snapshot complete and stable
//   ready_i    - consumer accepts the snapshot (only meaningful in HOLD)
//   busy_o     - scan or hold in progress
//   ovr_o      - sticky: a start request was dropped since the last accepted start
module mux_scan_capture
    import scan_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    output logic [SEL_W-1:0]  sel_o,
    input  logic [WIDTH-1:0]  din_i,
    output logic [SNAP_W-1:0] snap_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              busy_o,
    output logic              ovr_o
);

    localparam logic [CNT_W-1:0] SettleCnt = CNT_W'(SETTLE);
    localparam logic [SEL_W-1:0] LastSel   = SEL_W'(NUM_SRC - 1);

    scan_state_t      state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             slot_we;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        slot_we = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    sel_d   = '0;
                    cnt_d   = SettleCnt;
                    ovr_d   = 1'b0;
                    state_d = StScan;
                end
            end
            StScan: begin
                if (start_i) begin
                    ovr_d = 1'b1;
                end
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    // Settle time elapsed: din_i now reflects the current select.
                    slot_we = 1'b1;
                    if (sel_q == LastSel) begin
                        state_d = StHold;
                        valid_d = 1'b1;
                    end else begin
                        sel_d = sel_q + SEL_W'(1);
                        cnt_d = SettleCnt;
                    end
                end
            end
            StHold: begin
                if (ready_i) begin
                    valid_d = 1'b0;
                    sel_d   = '0;
                    if (start_i) begin
                        // Restart in the handshake cycle: no idle cycle between scans.
                        cnt_d   = SettleCnt;
                        ovr_d   = 1'b0;
                        state_d = StScan;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (start_i) begin
                    ovr_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sel_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    slot_bank u_slot_bank (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (slot_we),
        .idx   (sel_q),
        .d     (din_i),
        .q     (snap_o)
    );

    assign sel_o   = sel_q;
    assign valid_o = valid_q;
    assign ovr_o   = ovr_q;
    assign busy_o  = (state_q != StIdle);

endmodule

// File: tb/tb_mux_scan_capture.sv
// Self-checking bench for mux_scan_capture. Two instances: dut0 with SETTLE=1 and
// dut1 with SETTLE=0, each driving its own behavioural 6:1 mux model.
module tb_mux_scan_capture;

    localparam int S0 = 1;
    localparam int S1 = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start0, ready0, valid0, busy0, ovr0;
    logic        start1, ready1, valid1, busy1, ovr1;
    logic [2:0]  sel0, sel1;
    logic [3:0]  din0, din1;
    logic [23:0] snap0, snap1;
    logic [23:0] srcv0, srcv1;   // packed mux sources, source i at [4i+3:4i]

    // Mux models: a select outside 0..5 yields X
    always_comb din0 = (sel0 < 3'd6) ? srcv0[{sel0, 2'b00} +: 4] : 4'hx;
    always_comb din1 = (sel1 < 3'd6) ? srcv1[{sel1, 2'b00} +: 4] : 4'hx;

    mux_scan_capture #(.SETTLE(S0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start_i(start0), .sel_o(sel0), .din_i(din0),
        .snap_o(snap0), .valid_o(valid0), .ready_i(ready0), .busy_o(busy0), .ovr_o(ovr0)
    );

    mux_scan_capture #(.SETTLE(S1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start_i(start1), .sel_o(sel1), .din_i(din1),
        .snap_o(snap1), .valid_o(valid1), .ready_i(ready1), .busy_o(busy1), .ovr_o(ovr1)
    );

    int checks = 0;
    int errors = 0;
    int cur    = 0;   // which instance the current test drives

    logic [2:0]  o_sel;
    logic [23:0] o_snap;
    logic        o_valid, o_busy, o_ovr;
    always_comb begin
        o_sel   = (cur == 1) ? sel1   : sel0;
        o_snap  = (cur == 1) ? snap1  : snap0;
        o_valid = (cur == 1) ? valid1 : valid0;
        o_busy  = (cur == 1) ? busy1  : busy0;
        o_ovr   = (cur == 1) ? ovr1   : ovr0;
    end

    logic [2:0] sel_log   [64];
    logic       busy_log  [64];
    logic       valid_log [64];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic rd);
        if (cur == 1) begin
            start1 = st; ready1 = rd;
        end else begin
            start0 = st; ready0 = rd;
        end
    endtask

    task automatic set_src(input logic [23:0] v);
        if (cur == 1) srcv1 = v;
        else          srcv0 = v;
    endtask

    function automatic int settle();
        return (cur == 1) ? S1 : S0;
    endfunction

    task automatic accept();
        drive(1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b0);
    endtask

    task automatic handshake();
        drive(1'b0, 1'b1);
        tick();
        drive(1'b0, 1'b0);
    endtask

    // Runs from the cycle after an accepted start until valid rises (bounded),
    // logging outputs per cycle. Optionally pulses start in cycle drop_at and
    // wiggles ready randomly. cycles = -1 when the bound expires.
    task automatic run_scan(input int drop_at, input bit noise, output int cycles);
        cycles = -1;
        for (int k = 0; k < 64; k++) begin
            sel_log[k]   = o_sel;
            busy_log[k]  = o_busy;
            valid_log[k] = o_valid;
            drive(k == drop_at, noise ? 1'($urandom_range(0, 1)) : 1'b0);
            tick();
            if (o_valid) begin
                cycles = k + 1;
                break;
            end
        end
        drive(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start0 = 1'b0; ready0 = 1'b0; start1 = 1'b0; ready1 = 1'b0;
        srcv0 = '0; srcv1 = '0;
        #12;
        checks++;
        if ({sel0, valid0, busy0, ovr0, snap0} !== '0) begin
            errors++;
            $display("FAIL reset_dut0: sel=%0d valid=%b busy=%b ovr=%b snap=%h, required all 0",
                     sel0, valid0, busy0, ovr0, snap0);
        end
        checks++;
        if ({sel1, valid1, busy1, ovr1, snap1} !== '0) begin
            errors++;
            $display("FAIL reset_dut1: sel=%0d valid=%b busy=%b ovr=%b snap=%h, required all 0",
                     sel1, valid1, busy1, ovr1, snap1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if ({valid0, busy0, valid1, busy1} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_idle: valid/busy=%b%b%b%b, required 0000",
                     valid0, busy0, valid1, busy1);
        end
    endtask

    task automatic test_basic_scan();
        int cyc;
        int s;
        cur = 0;
        s = settle();
        set_src(24'h654321);
        accept();
        run_scan(-1, 1'b0, cyc);
        checks++;
        if (cyc != 6 * (s + 1)) begin
            errors++;
            $display("FAIL basic_latency: valid after %0d cycles, required %0d", cyc, 6 * (s + 1));
        end
        for (int k = 0; k < 6 * (s + 1); k++) begin
            checks++;
            if (sel_log[k] !== 3'(k / (s + 1)) || busy_log[k] !== 1'b1 || valid_log[k] !== 1'b0) begin
                errors++;
                $display("FAIL basic_seq k=%0d: sel=%0d busy=%b valid=%b, required sel=%0d busy=1 valid=0",
                         k, sel_log[k], busy_log[k], valid_log[k], k / (s + 1));
            end
        end
        checks++;
        if (o_snap !== 24'h654321 || o_ovr !== 1'b0 || o_sel !== 3'd5) begin
            errors++;
            $display("FAIL basic_snap: snap=%h ovr=%b sel=%0d, required 654321 0 5",
                     o_snap, o_ovr, o_sel);
        end
    endtask

    task automatic test_hold_off();
        cur = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (o_valid !== 1'b1 || o_snap !== 24'h654321 || o_sel !== 3'd5 || o_busy !== 1'b1) begin
                errors++;
                $display("FAIL hold_stable k=%0d: valid=%b snap=%h sel=%0d busy=%b, required 1 654321 5 1",
                         k, o_valid, o_snap, o_sel, o_busy);
            end
        end
        handshake();
        checks++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_sel !== 3'd0) begin
            errors++;
            $display("FAIL hold_release: valid=%b busy=%b sel=%0d, required 0 0 0",
                     o_valid, o_busy, o_sel);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        cur = 0;
        set_src(24'h654321);
        accept();
        run_scan(-1, 1'b0, cyc);
        set_src(24'hEDCBA9);
        tick();
        checks++;
        if (o_snap !== 24'h654321 || o_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_hold_snap: snap=%h valid=%b, required 654321 1", o_snap, o_valid);
        end
        drive(1'b1, 1'b1);
        tick();
        drive(1'b0, 1'b0);
        checks++;
        if (o_busy !== 1'b1 || o_valid !== 1'b0 || o_sel !== 3'd0 || o_ovr !== 1'b0) begin
            errors++;
            $display("FAIL b2b_restart: busy=%b valid=%b sel=%0d ovr=%b, required 1 0 0 0",
                     o_busy, o_valid, o_sel, o_ovr);
        end
        run_scan(-1, 1'b0, cyc);
        checks++;
        if (cyc != 12 || o_snap !== 24'hEDCBA9 || o_ovr !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: cycles=%0d snap=%h ovr=%b, required 12 edcba9 0",
                     cyc, o_snap, o_ovr);
        end
        handshake();
    endtask

    task automatic test_dropped_start();
        int cyc;
        cur = 0;
        set_src(24'h2A7F03);
        accept();
        run_scan(5, 1'b0, cyc);
        checks++;
        if (cyc != 12 || o_snap !== 24'h2A7F03 || o_ovr !== 1'b1) begin
            errors++;
            $display("FAIL drop_scan: cycles=%0d snap=%h ovr=%b, required 12 2a7f03 1",
                     cyc, o_snap, o_ovr);
        end
        tick();
        checks++;
        if (o_ovr !== 1'b1 || o_valid !== 1'b1) begin
            errors++;
            $display("FAIL drop_sticky: ovr=%b valid=%b, required 1 1", o_ovr, o_valid);
        end
        handshake();
        accept();
        checks++;
        if (o_ovr !== 1'b0 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL drop_clear: ovr=%b busy=%b, required 0 1", o_ovr, o_busy);
        end
        run_scan(-1, 1'b0, cyc);
        // Start while holding without ready is also dropped
        drive(1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b0);
        checks++;
        if (o_ovr !== 1'b1 || o_valid !== 1'b1 || o_snap !== 24'h2A7F03) begin
            errors++;
            $display("FAIL drop_in_hold: ovr=%b valid=%b snap=%h, required 1 1 2a7f03",
                     o_ovr, o_valid, o_snap);
        end
        handshake();
    endtask

    task automatic test_settle0();
        int cyc;
        cur = 1;
        set_src(24'h654321);
        accept();
        run_scan(-1, 1'b0, cyc);
        checks++;
        if (cyc != 6 || o_snap !== 24'h654321) begin
            errors++;
            $display("FAIL settle0: cycles=%0d snap=%h, required 6 654321", cyc, o_snap);
        end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (sel_log[k] !== 3'(k)) begin
                errors++;
                $display("FAIL settle0_seq k=%0d: sel=%0d, required %0d", k, sel_log[k], k);
            end
        end
        handshake();
    endtask

    task automatic test_random();
        int          cyc;
        int          s;
        int          drop;
        int          hold;
        logic        hst;
        logic        exp_ovr;
        logic [23:0] v;
        for (int it = 0; it < 12; it++) begin
            cur = it % 2;
            s = settle();
            v = 24'($urandom);
            set_src(v);
            drop = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 6 * (s + 1) - 1)) : -1;
            exp_ovr = (drop >= 0);
            accept();
            run_scan(drop, 1'b1, cyc);
            checks++;
            if (cyc != 6 * (s + 1) || o_snap !== v || o_ovr !== exp_ovr) begin
                errors++;
                $display("FAIL rand_scan it=%0d: cycles=%0d snap=%h ovr=%b, required %0d %h %b",
                         it, cyc, o_snap, o_ovr, 6 * (s + 1), v, exp_ovr);
            end
            set_src(~v);
            hold = $urandom_range(0, 4);
            for (int h = 0; h < hold; h++) begin
                hst = 1'($urandom_range(0, 1));
                exp_ovr = exp_ovr | hst;
                drive(hst, 1'b0);
                tick();
                drive(1'b0, 1'b0);
                checks++;
                if (o_snap !== v || o_valid !== 1'b1 || o_ovr !== exp_ovr || o_sel !== 3'd5) begin
                    errors++;
                    $display("FAIL rand_hold it=%0d: snap=%h valid=%b ovr=%b sel=%0d, required %h 1 %b 5",
                             it, o_snap, o_valid, o_ovr, o_sel, v, exp_ovr);
                end
            end
            handshake();
            checks++;
            if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_sel !== 3'd0) begin
                errors++;
                $display("FAIL rand_release it=%0d: valid=%b busy=%b sel=%0d, required 0 0 0",
                         it, o_valid, o_busy, o_sel);
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        cur = 0;
        set_src(24'h13579B);
        accept();
        for (int k = 0; k < 7; k++) begin
            drive(k == 2, 1'b0);
            tick();
        end
        drive(1'b0, 1'b0);
        checks++;
        if (o_ovr !== 1'b1 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL midscan_pre: ovr=%b busy=%b, required 1 1", o_ovr, o_busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({sel0, valid0, busy0, ovr0, snap0} !== '0) begin
            errors++;
            $display("FAIL midscan_async: sel=%0d valid=%b busy=%b ovr=%b snap=%h, required all 0",
                     sel0, valid0, busy0, ovr0, snap0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            checks++;
            if (valid0 !== 1'b0 || busy0 !== 1'b0 || sel0 !== 3'd0) begin
                errors++;
                $display("FAIL midscan_after k=%0d: valid=%b busy=%b sel=%0d, required 0 0 0",
                         k, valid0, busy0, sel0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_hold_off();
        test_back_to_back();
        test_dropped_start();
        test_settle0();
        test_random();
        test_reset_mid_scan();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
